// File: rtl/apb_ahb_bridge.sv
// APB4 slave to AHB-Lite master bridge: each APB transfer is replayed as one
// NONSEQ/SINGLE AHB transfer while the APB access phase is stalled via p_ready.
module apb_ahb_bridge #(
   parameter logic [31:0] ADDR_OFFSET = 32'h0000_0000
) (
   input  logic        h_clk,
   input  logic        h_resetn,
   input  logic [31:0] p_addr,
   input  logic        p_sel,
   input  logic        p_enable,
   input  logic        p_write,
   input  logic [31:0] p_wdata,
   input  logic [3:0]  p_strb,
   output logic [31:0] p_rdata,
   output logic        p_ready,
   output logic        p_slverr,
   output logic [31:0] h_addr,
   output logic [2:0]  h_burst,
   output logic [2:0]  h_size,
   output logic [1:0]  h_trans,
   output logic        h_write,
   output logic [31:0] h_wdata,
   output logic [3:0]  h_wstrb,
   input  logic [31:0] h_rdata,
   input  logic        h_ready,
   input  logic        h_resp
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic [1:0]  state;
   logic [2:0]  dec_size;
   logic [1:0]  dec_off;
   logic        dec_xfer;
   logic        dec_err;
   logic [31:0] ahb_addr;

   // Strobe patterns that map onto a naturally aligned AHB size are transferred;
   // an empty strobe completes silently, anything else is rejected with an error.
   always_comb begin
      dec_size = 3'b010;
      dec_off  = 2'd0;
      dec_xfer = 1'b1;
      dec_err  = 1'b0;
      if (p_write) begin
         case (p_strb)
            4'b1111: ;
            4'b0011: dec_size = 3'b001;
            4'b1100: begin dec_size = 3'b001; dec_off = 2'd2; end
            4'b0001: dec_size = 3'b000;
            4'b0010: begin dec_size = 3'b000; dec_off = 2'd1; end
            4'b0100: begin dec_size = 3'b000; dec_off = 2'd2; end
            4'b1000: begin dec_size = 3'b000; dec_off = 2'd3; end
            4'b0000: dec_xfer = 1'b0;
            default: begin dec_xfer = 1'b0; dec_err = 1'b1; end
         endcase
      end
   end

   assign ahb_addr = (p_addr & 32'hFFFF_FFFC) + ADDR_OFFSET + {30'd0, dec_off};
   assign h_burst  = 3'b000;

   always_ff @(posedge h_clk or negedge h_resetn) begin
      if (!h_resetn) begin
         state    <= IDLE;
         h_trans  <= TRANS_IDLE;
         h_addr   <= '0;
         h_size   <= '0;
         h_write  <= 1'b0;
         h_wdata  <= '0;
         h_wstrb  <= '0;
         p_ready  <= 1'b0;
         p_slverr <= 1'b0;
         p_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (p_sel && !p_enable) begin
                  if (dec_xfer) begin
                     state   <= ADDR;
                     h_trans <= TRANS_NONSEQ;
                     h_addr  <= ahb_addr;
                     h_size  <= dec_size;
                     h_write <= p_write;
                     h_wdata <= p_wdata;
                     h_wstrb <= p_write ? p_strb : 4'b0000;
                  end else begin
                     state    <= DONE;
                     p_ready  <= 1'b1;
                     p_slverr <= dec_err;
                  end
               end
            end
            ADDR: begin
               if (h_ready) begin
                  state   <= DATA;
                  h_trans <= TRANS_IDLE;
               end
            end
            DATA: begin
               // First ERROR cycle (h_ready low) simply waits; the response is taken on the second.
               if (h_ready) begin
                  state    <= DONE;
                  p_ready  <= 1'b1;
                  p_slverr <= h_resp;
                  if (!h_write) p_rdata <= h_rdata;
               end
            end
            DONE: begin
               state    <= IDLE;
               p_ready  <= 1'b0;
               p_slverr <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
